// File: rtl/tick_sched_pkg.sv
// ----------------------------------------------------------------------------
// tick_sched_pkg
// Shared types and constants for the pong timebase controller.
//   ch_state_t              : per-channel FSM state (CH_IDLE / CH_RUN)
//   DEF_CLK_DIV/NCH/CW      : default prescaler divide, channel count, width
//   CH_PADDLE..CH_SPARE     : channel index assigned to each game consumer
// Optional feature macro used by tick_scheduler: TICK_SCHED_PAUSE_EN
// ----------------------------------------------------------------------------
package tick_sched_pkg;

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_RUN  = 1'b1
    } ch_state_t;

    localparam int DEF_CLK_DIV = 100000;
    localparam int DEF_NCH     = 4;
    localparam int DEF_CW      = 16;

    // Channel allocation for the game consumers.
    localparam int CH_PADDLE = 0;  // paddle switch sampling
    localparam int CH_BALL   = 1;  // ball step
    localparam int CH_TIMER  = 2;  // time-mode countdown
    localparam int CH_SPARE  = 3;  // unallocated

endpackage

// File: rtl/tick_channel.sv
// ----------------------------------------------------------------------------
// tick_channel
// One scheduler channel: an IDLE/RUN FSM with a down-counter that divides the
// shared base tick by (reload+1), in periodic or one-shot mode.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   start, stop     : 1-cycle strobes; stop has priority over start
//   oneshot, reload : mode and reload, latched only on start
//   base_tick       : shared prescaler pulse (already gated by any pause)
//   tick_out        : registered 1-cycle pulse when the count expires
//   busy            : channel is in CH_RUN
// ----------------------------------------------------------------------------
module tick_channel
    import tick_sched_pkg::*;
#(
    parameter int CW = DEF_CW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          stop,
    input  logic          oneshot,
    input  logic [CW-1:0] reload,
    input  logic          base_tick,
    output logic          tick_out,
    output logic          busy
);

    ch_state_t     state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [CW-1:0] rl_q, rl_n;
    logic          os_q, os_n;
    logic          tick_q, tick_n;

    // NOTE: every register, including the latched reload/mode, is cleared by
    // the asynchronous reset so no channel can come up mid-count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= CH_IDLE;
            cnt    <= '0;
            rl_q   <= '0;
            os_q   <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all state updates see the
            // pre-edge values, independent of statement order.
            state  <= state_n;
            cnt    <= cnt_n;
            rl_q   <= rl_n;
            os_q   <= os_n;
            tick_q <= tick_n;
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every output and no
        // latch is inferred.
        state_n = state;
        cnt_n   = cnt;
        rl_n    = rl_q;
        os_n    = os_q;
        tick_n  = 1'b0;

        if (stop) begin
            // Stop wins over start and suppresses any tick due on this edge.
            state_n = CH_IDLE;
            cnt_n   = '0;
        end else if (start) begin
            // (Re)start discards the pending count and ignores a coincident
            // base tick.
            state_n = CH_RUN;
            cnt_n   = reload;
            rl_n    = reload;
            os_n    = oneshot;
        end else if (state == CH_RUN && base_tick) begin
            if (cnt != '0) begin
                cnt_n = cnt - CW'(1);
            end else begin
                tick_n = 1'b1;
                if (os_q) begin
                    state_n = CH_IDLE;
                end else begin
                    cnt_n = rl_q;
                end
            end
        end
    end

    assign tick_out = tick_q;
    assign busy     = (state == CH_RUN);

endmodule

// File: rtl/tick_scheduler.sv
// ----------------------------------------------------------------------------
// tick_scheduler
// Shared timebase for the pong game: one prescaler emits base_tick every
// CLK_DIV+1 clocks and NCH tick_channel instances subdivide it.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : [NCH] per-channel start/restart strobe
//   stop       : [NCH] per-channel stop strobe
//   oneshot    : [NCH] mode sampled with start (1 = one-shot)
//   reload     : [NCH*CW] channel i reload in bits [i*CW +: CW]
//   pause      : global freeze, honoured only with TICK_SCHED_PAUSE_EN
//   base_tick  : prescaler pulse
//   tick_out   : [NCH] per-channel registered pulse
//   busy       : [NCH] channel running
// Macro: TICK_SCHED_PAUSE_EN -- when defined, pause holds the prescaler,
// masks base_tick and thereby freezes all channel counters.
// ----------------------------------------------------------------------------
module tick_scheduler
    import tick_sched_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV,
    parameter int NCH     = DEF_NCH,
    parameter int CW      = DEF_CW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NCH-1:0]    start,
    input  logic [NCH-1:0]    stop,
    input  logic [NCH-1:0]    oneshot,
    input  logic [NCH*CW-1:0] reload,
    input  logic              pause,
    output logic              base_tick,
    output logic [NCH-1:0]    tick_out,
    output logic [NCH-1:0]    busy
);

    localparam int            PW      = (CLK_DIV < 1) ? 1 : $clog2(CLK_DIV + 1);
    localparam logic [PW-1:0] DIV_MAX = PW'(CLK_DIV);

    logic [PW-1:0] presc;
    logic          base_q;
    logic          hold;

`ifdef TICK_SCHED_PAUSE_EN
    assign hold = pause;
`else
    logic unused_pause;
    assign hold         = 1'b0;
    assign unused_pause = pause;
`endif

    // While held, base_q keeps its value too, so a pulse that was due when
    // pause rose is delivered on release rather than lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc  <= '0;
            base_q <= 1'b0;
        end else if (!hold) begin
            presc  <= (presc == DIV_MAX) ? '0 : presc + PW'(1);
            base_q <= (presc == DIV_MAX);
        end
    end

    assign base_tick = base_q & ~hold;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        tick_channel #(
            .CW(CW)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .start     (start[i]),
            .stop      (stop[i]),
            .oneshot   (oneshot[i]),
            .reload    (reload[i*CW +: CW]),
            .base_tick (base_tick),
            .tick_out  (tick_out[i]),
            .busy      (busy[i])
        );
    end

endmodule
